// File: rtl/relu_tile_sequencer.sv
// Tile sequencer for the 8x8 ReLU array: loads a tile row by row from SRAM, applies
// the array, writes the rectified rows back. Optional counters under RELU_SEQ_PERF_EN.
module relu_tile_sequencer #(
  parameter int SIZE   = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic [ADDR_W-1:0]                      src_base,
  input  logic [ADDR_W-1:0]                      dst_base,
  input  logic [CNT_W-1:0]                       num_tiles,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   rd_en,
  output logic [ADDR_W-1:0]                      rd_addr,
  input  logic [SIZE*DATA_W-1:0]                 rd_data,
  output logic                                   wr_en,
  input  logic                                   wr_ready,
  output logic [ADDR_W-1:0]                      wr_addr,
  output logic [SIZE*DATA_W-1:0]                 wr_data,
  output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]  relu_in,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]  relu_out
`ifdef RELU_SEQ_PERF_EN
  ,
  output logic [31:0]                            stall_cycles,
  output logic [CNT_W-1:0]                       tiles_done
`endif
);

  localparam int IDX_W = $clog2(SIZE);
  localparam int ROW_W = IDX_W + 1;
  localparam logic [ROW_W-1:0] ROW_ZERO      = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE       = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0] ROW_LOAD_END  = ROW_W'(SIZE);
  localparam logic [ROW_W-1:0] ROW_STORE_END = ROW_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_APPLY = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_t;

  state_t              state_q, state_d, state_nxt;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    tile_cnt_q, tile_cnt_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  tile_t               tile_q, tile_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [SIZE*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [IDX_W-1:0]    cap_idx;
  logic                last_tile;
`ifdef RELU_SEQ_PERF_EN
  logic [31:0]         stall_q, stall_d;
`endif

  // Row address = base + tile*SIZE + row, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] row_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [CNT_W-1:0]  tile,
                                                 input logic [ROW_W-1:0]  row);
    logic [ADDR_W+CNT_W+ROW_W-1:0] sum;
    sum = {{(CNT_W+ROW_W){1'b0}}, base}
        + {{(ADDR_W+ROW_W-IDX_W){1'b0}}, tile, {IDX_W{1'b0}}}
        + {{(ADDR_W+CNT_W){1'b0}}, row};
    return sum[ADDR_W-1:0];
  endfunction

  assign cap_idx   = row_q[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
  assign last_tile = (({1'b0, tile_cnt_q} + {1'b0, CNT_ONE}) == {1'b0, num_q});

  // Next-state and next-output computation; outputs are registered from next-state values.
  always_comb begin
    state_nxt  = state_q;
    row_d      = row_q;
    tile_cnt_d = tile_cnt_q;
    num_d      = num_q;
    src_d      = src_q;
    dst_d      = dst_q;
    tile_d     = tile_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d      = src_base;
          dst_d      = dst_base;
          num_d      = num_tiles;
          tile_cnt_d = CNT_ZERO;
          row_d      = ROW_ZERO;
          state_nxt  = (num_tiles == CNT_ZERO) ? ST_DONE : ST_LOAD;
        end else begin
          state_nxt  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Read data lags rd_en by one cycle, so row_cnt captures into row row_cnt-1.
        if (row_q != ROW_ZERO) begin
          tile_d[cap_idx] = rd_data;
        end else begin
          tile_d = tile_q;
        end
        if (row_q == ROW_LOAD_END) begin
          state_nxt = ST_APPLY;
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end
      ST_APPLY: begin
        tile_d    = relu_out;
        row_d     = ROW_ZERO;
        state_nxt = ST_STORE;
      end
      ST_STORE: begin
        if (wr_en_q && wr_ready) begin
          if (row_q == ROW_STORE_END) begin
            tile_cnt_d = tile_cnt_q + CNT_ONE;
            row_d      = ROW_ZERO;
            state_nxt  = last_tile ? ST_DONE : ST_LOAD;
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end else begin
          state_nxt = ST_STORE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    state_d   = (abort && (state_q != ST_IDLE)) ? ST_IDLE : state_nxt;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    rd_en_d   = (state_d == ST_LOAD) && (row_d < ROW_LOAD_END);
    rd_addr_d = rd_en_d ? row_addr(src_d, tile_cnt_d, row_d) : rd_addr_q;
    wr_en_d   = (state_d == ST_STORE);
    wr_addr_d = wr_en_d ? row_addr(dst_d, tile_cnt_d, row_d) : wr_addr_q;
    wr_data_d = wr_en_d ? tile_d[row_d[IDX_W-1:0]] : wr_data_q;

`ifdef RELU_SEQ_PERF_EN
    if ((state_q == ST_IDLE) && start) begin
      stall_d = 32'd0;
    end else if (wr_en_q && !wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
`endif
  end

  // State, tile register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= ROW_ZERO;
      tile_cnt_q <= CNT_ZERO;
      num_q      <= CNT_ZERO;
      src_q      <= {ADDR_W{1'b0}};
      dst_q      <= {ADDR_W{1'b0}};
      tile_q     <= {(SIZE*SIZE*DATA_W){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_addr_q  <= {ADDR_W{1'b0}};
      wr_addr_q  <= {ADDR_W{1'b0}};
      wr_data_q  <= {(SIZE*DATA_W){1'b0}};
`ifdef RELU_SEQ_PERF_EN
      stall_q    <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      tile_cnt_q <= tile_cnt_d;
      num_q      <= num_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      tile_q     <= tile_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef RELU_SEQ_PERF_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign relu_in = tile_q;
`ifdef RELU_SEQ_PERF_EN
  assign stall_cycles = stall_q;
  assign tiles_done   = tile_cnt_q;
`endif

endmodule

// File: tb/tb_relu_tile_sequencer.sv
// Bench for relu_tile_sequencer: SRAM + ReLU array models, scoreboarded reads/writes,
// a vector table of runs and hand-written abort/reset/ignored-start sequences.
module tb_relu_tile_sequencer;

  localparam int SIZE = 8, DATA_W = 32, ADDR_W = 12, CNT_W = 8;
  localparam int ROW_BITS = SIZE * DATA_W;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [ROW_BITS-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [CNT_W-1:0]  nt;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    int                stall_beat;
    int                stall_len;
    bit                sign_pat;
    int                exp_lat;
  } vec_t;

  logic clk, rst_n, start, abort;
  logic [ADDR_W-1:0] src_base, dst_base, rd_addr, wr_addr;
  logic [CNT_W-1:0]  num_tiles;
  logic busy, done, rd_en, wr_en;
  logic wr_ready = 1'b1;
  logic [ROW_BITS-1:0] rd_data, wr_data;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] relu_in, relu_out;
`ifdef RELU_SEQ_PERF_EN
  logic [31:0]      stall_cycles;
  logic [CNT_W-1:0] tiles_done;
`endif

  logic [ROW_BITS-1:0] mem [0:4095];
  logic [ROW_BITS-1:0] marker;

  wr_exp_t           exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int beats_total = 0, stalls_total = 0, rd_total = 0, wr_total = 0, done_total = 0, done_cyc = 0;
  int beat_base = 0, stall_base = 0, stall_beat = -1, stall_len = 0, done_base = 0, start_cyc = 0;

  relu_tile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .num_tiles(num_tiles),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .relu_in(relu_in), .relu_out(relu_out)
`ifdef RELU_SEQ_PERF_EN
    , .stall_cycles(stall_cycles), .tiles_done(tiles_done)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: one-cycle read latency, write on an accepted beat.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en && wr_ready) mem[wr_addr] = wr_data;
  end

  // Combinational ReLU array model.
  always_comb begin
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        relu_out[r][c] = relu_in[r][c][DATA_W-1] ? 32'h0000_0000 : relu_in[r][c];
  end

  function automatic logic [ROW_BITS-1:0] relu_row(input logic [ROW_BITS-1:0] row);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < SIZE; k++) begin
      w = row[k*DATA_W +: DATA_W];
      relu_row[k*DATA_W +: DATA_W] = w[DATA_W-1] ? 32'h0000_0000 : w;
    end
  endfunction

  task automatic check(input string name, input logic [ROW_BITS-1:0] act, input logic [ROW_BITS-1:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event where none was expected", name);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor/scoreboard on the falling edge; also drives wr_ready backpressure.
  always @(negedge clk) begin
    wr_exp_t w;
    if (done) begin
      done_total++;
      done_cyc = cyc;
    end
    if (rd_en) begin
      rd_total++;
      check("rd_wr_exclusive", wr_en, 0);
      if (exp_rd.size() == 0) fail_now("unexpected_read");
      else check("rd_addr", rd_addr, exp_rd.pop_front());
    end
    if (wr_en) begin
      wr_total++;
      if ((beats_total - beat_base) == stall_beat && (stalls_total - stall_base) < stall_len) begin
        wr_ready = 1'b0;
        stalls_total++;
      end else begin
        wr_ready = 1'b1;
      end
      if (exp_wr.size() == 0) fail_now("unexpected_write");
      else begin
        w = exp_wr[0];
        check(wr_ready ? "wr_addr" : "wr_addr_stall", wr_addr, w.addr);
        check(wr_ready ? "wr_data" : "wr_data_stall", wr_data, w.data);
        if (wr_ready) begin
          w = exp_wr.pop_front();
          beats_total++;
        end
      end
    end else begin
      wr_ready = 1'b1;
    end
  end

  task automatic kick(input logic [CNT_W-1:0] nt, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                      input int sbeat, input int slen, input bit sign_pat);
    logic [ROW_BITS-1:0] row;
    logic [ADDR_W-1:0]   a;
    wr_exp_t             w;
    for (int t = 0; t < int'(nt); t++) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++)
          row[k*DATA_W +: DATA_W] = sign_pat ? ((k % 2 == 0) ? 32'hFFFF_FFF6 : 32'h0000_000A) : $urandom;
        a = src + ADDR_W'(t*SIZE + r);
        mem[a] = row;
        exp_rd.push_back(a);
        w.addr = dst + ADDR_W'(t*SIZE + r);
        w.data = relu_row(row);
        exp_wr.push_back(w);
      end
    end
    beat_base  = beats_total;
    stall_base = stalls_total;
    stall_beat = sbeat;
    stall_len  = slen;
    done_base  = done_total;
    src_base   = src;
    dst_base   = dst;
    num_tiles  = nt;
    start      = 1'b1;
    start_cyc  = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_total == done_base && i < budget) begin
      step();
      i++;
    end
    if (done_total == done_base) fail_now("done_timeout");
  endtask

  task automatic run_vec(input vec_t v);
    logic [ROW_BITS-1:0] e;
    kick(v.nt, v.src, v.dst, v.stall_beat, v.stall_len, v.sign_pat);
    wait_done(400);
    check("latency", done_cyc - start_cyc, v.exp_lat);
    repeat (3) step();
    check("done_count", done_total - done_base, 1);
    check("rd_drain", exp_rd.size(), 0);
    check("wr_drain", exp_wr.size(), 0);
    check("busy_after", busy, 0);
`ifdef RELU_SEQ_PERF_EN
    check("stall_cycles", stall_cycles, v.stall_len);
    check("tiles_done", tiles_done, v.nt);
`endif
    if (v.sign_pat) begin
      for (int k = 0; k < SIZE; k++) e[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 32'h0000_0000 : 32'h0000_000A;
      for (int r = 0; r < SIZE; r++) check("sign_row", mem[v.dst + ADDR_W'(r)], e);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   snap;
    vecs[0] = '{nt: 8'd1, src: 12'h010, dst: 12'h100, stall_beat: -1, stall_len: 0, sign_pat: 1'b1, exp_lat: 19};
    vecs[1] = '{nt: 8'd3, src: 12'h000, dst: 12'h200, stall_beat: -1, stall_len: 0, sign_pat: 1'b0, exp_lat: 55};
    vecs[2] = '{nt: 8'd1, src: 12'h040, dst: 12'h300, stall_beat: 2,  stall_len: 4, sign_pat: 1'b0, exp_lat: 23};
    vecs[3] = '{nt: 8'd1, src: 12'hFFC, dst: 12'h800, stall_beat: -1, stall_len: 0, sign_pat: 1'b0, exp_lat: 19};
    vecs[4] = '{nt: 8'd2, src: 12'h400, dst: 12'hFFC, stall_beat: 5,  stall_len: 2, sign_pat: 1'b0, exp_lat: 39};
    marker = {8{32'hDEAD_BEEF}};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_base = 12'h000; dst_base = 12'h000; num_tiles = 8'd0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_relu_in", (relu_in == '0), 1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Zero tiles: done one cycle after start, no SRAM traffic.
    snap = rd_total + wr_total;
    kick(8'd0, 12'h123, 12'h456, -1, 0, 1'b0);
    wait_done(20);
    check("zero_latency", done_cyc - start_cyc, 1);
    repeat (3) step();
    check("zero_traffic", rd_total + wr_total - snap, 0);
    check("zero_done_count", done_total - done_base, 1);

    // Start while busy is ignored.
    kick(8'd1, 12'h010, 12'h140, -1, 0, 1'b0);
    repeat (5) step();
    src_base = 12'h500; dst_base = 12'h600; num_tiles = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(100);
    check("ignored_latency", done_cyc - start_cyc, 19);
    repeat (3) step();
    check("ignored_done_count", done_total - done_base, 1);
    check("ignored_wr_drain", exp_wr.size(), 0);

    // Abort while beat 4 is being accepted.
    for (int r = 0; r < SIZE; r++) mem[12'h700 + ADDR_W'(r)] = marker;
    kick(8'd1, 12'h020, 12'h700, -1, 0, 1'b0);
    snap = 0;
    while ((beats_total - beat_base) < 5 && snap < 100) begin
      step();
      snap++;
    end
    check("abort_reached_beat4", beats_total - beat_base, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_wr_en", wr_en, 0);
    snap = wr_total;
    repeat (10) step();
    check("abort_no_writes", wr_total - snap, 0);
    check("abort_no_done", done_total - done_base, 0);
    check("abort_beat4_written", (mem[12'h704] == marker), 0);
    check("abort_beat5_untouched", mem[12'h705], marker);
    exp_wr.delete();
    exp_rd.delete();

    // Asynchronous reset during LOAD.
    kick(8'd1, 12'h030, 12'h180, -1, 0, 1'b0);
    repeat (3) step();
    check("pre_reset_rd_en", rd_en, 1);
    rst_n = 1'b0;
    #1;
    check("reset_rd_en", rd_en, 0);
    check("reset_busy", busy, 0);
    step();
    rst_n = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    snap = wr_total;
    repeat (25) step();
    check("reset_no_writes", wr_total - snap, 0);
    check("reset_no_done", done_total - done_base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_tile_sequencer.md
Name: relu_tile_sequencer

Overview:
- Sequences the 8x8 combinational ReLU array over a run of activation tiles held in an on-chip row-organised SRAM.
- Per tile:
  - reads 8 rows of 8 x 32-bit words into a tile register;
  - drives the tile register into the ReLU array and captures the array's result;
  - writes the 8 rectified rows back to a destination region.
- Sits between the layer controller (start/done) and the activation buffer.

Parameters:
- SIZE, 8, tile edge; rows per tile and words per row. Fixed at 8 to match the ReLU array.
- DATA_W, 32, word width.
- ADDR_W, 12, row address width. One address is one row of SIZE words.
- CNT_W, 8, width of the tile count.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe. Accepted only in IDLE.
- abort  in  1  synchronous abort request.
- src_base  in  ADDR_W  first source row address. Sampled on an accepted start.
- dst_base  in  ADDR_W  first destination row address. Sampled on an accepted start.
- num_tiles  in  CNT_W  number of tiles to process. Sampled on an accepted start.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse on completion.
- rd_en  out  1  SRAM read strobe.
- rd_addr  out  ADDR_W  SRAM read row address.
- rd_data  in  SIZE*DATA_W  read row data. Valid exactly 1 cycle after rd_en. Word k is bits [k*DATA_W +: DATA_W].
- wr_en  out  1  write request.
- wr_ready  in  1  write accept. A beat transfers when wr_en && wr_ready.
- wr_addr  out  ADDR_W  write row address.
- wr_data  out  SIZE*DATA_W  write row data. Same word packing as rd_data.
- relu_in  out  DATA_W x [SIZE][SIZE]  tile driven to the ReLU array. Equals the tile register.
- relu_out  in  DATA_W x [SIZE][SIZE]  rectified tile returned from the ReLU array.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, rd_en, wr_en go to 0.
  - rd_addr, wr_addr, wr_data, the tile register and all counters go to 0.
- IDLE:
  - start=1 latches the bases, num_tiles, tile_cnt=0 and row_cnt=0.
  - If num_tiles==0: go to DONE, with no SRAM accesses.
  - Otherwise go to LOAD.
- LOAD (row_cnt 0..8, 9 cycles):
  - While row_cnt<8: rd_en=1, rd_addr = src_base + tile_cnt*8 + row_cnt.
  - While row_cnt>=1: rd_data is captured into tile row row_cnt-1.
  - At row_cnt==8: go to APPLY.
- APPLY (1 cycle): tile register <= relu_out. Go to STORE with row_cnt=0.
- STORE:
  - wr_en=1, wr_addr = dst_base + tile_cnt*8 + row_cnt, wr_data = tile row row_cnt.
  - Address and data are held stable while wr_ready=0.
  - On each accepted beat, row_cnt increments.
  - After beat 7: tile_cnt increments. If tile_cnt+1==num_tiles go to DONE, else go to LOAD with row_cnt=0.
- DONE (1 cycle): done=1, then IDLE.
- Throughput without stalls: 18 cycles per tile.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- start while busy is ignored. Bases and count are not re-sampled.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - rd_en and wr_en drop in that next cycle; no done pulse.
  - abort takes priority over every other transition, including the final accepted write beat.
  - A write beat accepted in the same cycle as abort counts as transferred, but sequencing stops.
- Reset mid-operation: all outputs go to reset values asynchronously. No partial write is completed.
- rd_en and wr_en are never high in the same cycle.

Optional Feature:
- RELU_SEQ_PERF_EN:
  - Adds output stall_cycles (32 bits) and output tiles_done (CNT_W bits).
  - stall_cycles counts cycles with wr_en && !wr_ready. It saturates at all-ones.
  - tiles_done mirrors tile_cnt.
  - Both clear on an accepted start and on reset.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic sign test:
  - Stimulus: num_tiles=1, src_base=0x010, dst_base=0x100, wr_ready=1. Tile rows hold alternating words 0xFFFFFFF6 and 0x0000000A.
  - Required: rows 0x100..0x107 hold alternating 0x00000000 and 0x0000000A. done pulses exactly 19 cycles after start.
- Multi-tile:
  - Stimulus: num_tiles=3, src_base=0x000, dst_base=0x200.
  - Required: reads cover 0x000..0x017; writes cover 0x200..0x217 in order; one done pulse.
- Backpressure:
  - Stimulus: num_tiles=1; wr_ready held 0 for 4 cycles on beat 2, then 1.
  - Required: wr_addr and wr_data stable at dst_base+2 through the stall; total latency is 23 cycles.
  - With RELU_SEQ_PERF_EN: stall_cycles=4.
- Zero tiles and ignored start:
  - Stimulus: start with num_tiles=0.
  - Required: done pulses 1 cycle later; no rd_en or wr_en.
  - Stimulus: a second start while busy.
  - Required: no effect.
- Wrap-around:
  - Stimulus: src_base=0xFFC, num_tiles=1.
  - Required: rd_addr sequence is 0xFFC, 0xFFD, 0xFFE, 0xFFF, 0x000, 0x001, 0x002, 0x003.
- Abort and reset:
  - Stimulus: abort during STORE beat 4.
  - Required: IDLE next cycle, no done, no further writes.
  - Stimulus: rst_n low during LOAD.
  - Required: rd_en=0 immediately and busy=0.
